// File: rtl/acquisition_sequencer.sv
// Purpose: sequences one event-tagger acquisition (clear, run window, drain) and gates tagger records into the record FIFO.
// Latency: start -> RUN in 1 cycle (2 with timer clear); stop -> DRAIN next cycle, done one cycle later; fifo_wr is same-cycle.
// Backpressure: fifo_full drops the current tagger record (counted as lost, overflow set); the run halts on a loss only if halt_on_overflow.
module acquisition_sequencer #(
   parameter int DUR_W  = 36,
   parameter int CNT_W  = 32,
   parameter int LOST_W = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cmd_start,
   input  logic              cmd_stop,
   input  logic              clear_timer,
   input  logic              timed_mode,
   input  logic [DUR_W-1:0]  duration,
   input  logic              halt_on_overflow,
   input  logic              tagger_ready,
   input  logic              fifo_full,
   output logic              reset_counter,
   output logic              counter_operate,
   output logic              capture_operate,
   output logic              fifo_wr,
   output logic              busy,
   output logic              done,
   output logic              overflow,
   output logic [CNT_W-1:0]  record_count,
   output logic [LOST_W-1:0] lost_count
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_CLEAR = 3'd1,
      S_RUN   = 3'd2,
      S_DRAIN = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t            state;
   logic              timed_q;
   logic [DUR_W-1:0]  remaining;
   logic              accept_window;
   logic              lost;
   logic              window_end;

   // Tagger controls and status are pure decodes of the state register, so they never glitch.
   assign reset_counter   = (state == S_CLEAR);
   assign counter_operate = (state == S_RUN);
   assign capture_operate = (state == S_RUN);
   assign busy            = (state != S_IDLE);
   assign done            = (state == S_DONE);

   // DRAIN is inside the window because tagger_ready trails capture_operate by one cycle.
   assign accept_window = (state == S_RUN) || (state == S_DRAIN);
   assign fifo_wr       = tagger_ready & ~fifo_full & accept_window;
   assign lost          = tagger_ready &  fifo_full & accept_window;

   // A timed window ends on its last cycle, when one cycle of the duration remains.
   assign window_end = cmd_stop
                     | (timed_q && (remaining == DUR_W'(1)))
                     | (halt_on_overflow && lost);

   // Run sequencing, window countdown and saturating record/loss accounting.
   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= S_IDLE;
         timed_q      <= 1'b0;
         remaining    <= '0;
         record_count <= '0;
         lost_count   <= '0;
         overflow     <= 1'b0;
      end else begin
         if (fifo_wr && (record_count != '1)) begin
            record_count <= record_count + CNT_W'(1);
         end
         if (lost) begin
            overflow <= 1'b1;
            if (lost_count != '1) begin
               lost_count <= lost_count + LOST_W'(1);
            end
         end

         case (state)
            S_IDLE: begin
               if (cmd_start) begin
                  timed_q      <= timed_mode;
                  remaining    <= (duration == '0) ? DUR_W'(1) : duration;
                  record_count <= '0;
                  lost_count   <= '0;
                  overflow     <= 1'b0;
                  state        <= clear_timer ? S_CLEAR : S_RUN;
               end
            end
            S_CLEAR: begin
               state <= cmd_stop ? S_DRAIN : S_RUN;
            end
            S_RUN: begin
               if (timed_q && (remaining > DUR_W'(1))) begin
                  remaining <= remaining - DUR_W'(1);
               end
               if (window_end) begin
                  state <= S_DRAIN;
               end
            end
            S_DRAIN: begin
               state <= S_DONE;
            end
            S_DONE: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_acquisition_sequencer.sv
// Bench for acquisition_sequencer: directed scenarios with randomized tagger/FIFO traffic.
// Each run's stimulus is laid out per cycle offset; a window model predicts RUN span, done cycle and counts.
// Outputs are sampled on the falling edge; inputs change 1 time unit after the rising edge.
module tb_acquisition_sequencer;

   localparam int DUR_W  = 36;
   localparam int CNT_W  = 32;
   localparam int LOST_W = 16;
   localparam int MAXK   = 256;

   logic              clk = 1'b0;
   logic              reset;
   logic              cmd_start;
   logic              cmd_stop;
   logic              clear_timer;
   logic              timed_mode;
   logic [DUR_W-1:0]  duration;
   logic              halt_on_overflow;
   logic              tagger_ready;
   logic              fifo_full;
   logic              reset_counter;
   logic              counter_operate;
   logic              capture_operate;
   logic              fifo_wr;
   logic              busy;
   logic              done;
   logic              overflow;
   logic [CNT_W-1:0]  record_count;
   logic [LOST_W-1:0] lost_count;

   int n_assert = 0;
   int n_fail   = 0;

   // Stimulus per cycle offset (offset 0 is the cmd_start cycle) and what was observed there.
   bit               st[MAXK], sp[MAXK], rd[MAXK], fl[MAXK];
   logic             m_op[MAXK], m_cap[MAXK], m_rc[MAXK], m_dn[MAXK], m_bz[MAXK], m_wr[MAXK], m_ov[MAXK];
   logic [CNT_W-1:0] m_rcnt[MAXK];

   always #5 clk = ~clk;

   acquisition_sequencer #(.DUR_W(DUR_W), .CNT_W(CNT_W), .LOST_W(LOST_W)) dut (
      .clk              (clk),
      .reset            (reset),
      .cmd_start        (cmd_start),
      .cmd_stop         (cmd_stop),
      .clear_timer      (clear_timer),
      .timed_mode       (timed_mode),
      .duration         (duration),
      .halt_on_overflow (halt_on_overflow),
      .tagger_ready     (tagger_ready),
      .fifo_full        (fifo_full),
      .reset_counter    (reset_counter),
      .counter_operate  (counter_operate),
      .capture_operate  (capture_operate),
      .fifo_wr          (fifo_wr),
      .busy             (busy),
      .done             (done),
      .overflow         (overflow),
      .record_count     (record_count),
      .lost_count       (lost_count)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic clr_stim();
      for (int k = 0; k < MAXK; k++) begin
         st[k] = 1'b0; sp[k] = 1'b0; rd[k] = 1'b0; fl[k] = 1'b0;
      end
   endtask

   // Apply offsets 0..n-1; entered and left at rising edge + 1.
   task automatic play(input int n);
      for (int k = 0; k < n; k++) begin
         cmd_start    = st[k];
         cmd_stop     = sp[k];
         tagger_ready = rd[k];
         fifo_full    = fl[k];
         @(negedge clk);
         m_op[k]   = counter_operate;
         m_cap[k]  = capture_operate;
         m_rc[k]   = reset_counter;
         m_dn[k]   = done;
         m_bz[k]   = busy;
         m_wr[k]   = fifo_wr;
         m_ov[k]   = overflow;
         m_rcnt[k] = record_count;
         @(posedge clk);
         #1;
      end
      cmd_start = 1'b0; cmd_stop = 1'b0; tagger_ready = 1'b0; fifo_full = 1'b0;
   endtask

   // Window model: RUN opens 1 (+1 with clear) after start and closes on stop, on the
   // max(dur,1)-th RUN cycle when timed, or on a loss when halting. Records count in RUN plus one drain cycle.
   task automatic model(input bit clr, input bit timed, input bit halt, input int dur,
                        output int rf, output int last, output int rec, output int lst);
      int d1;
      d1   = (dur == 0) ? 1 : dur;
      rf   = 1 + int'(clr);
      last = -1;
      rec  = 0;
      lst  = 0;
      for (int k = rf; k < MAXK - 4; k++) begin
         if (sp[k] || (timed && (k - rf + 1 == d1)) || (halt && rd[k] && fl[k])) begin
            last = k;
            break;
         end
      end
      if (last >= 0) begin
         for (int k = rf; k <= last + 1; k++) begin
            if (rd[k]) begin
               if (fl[k]) lst++;
               else rec++;
            end
         end
      end
   endtask

   task automatic run_and_check(input string tg, input bit clr, input bit timed, input bit halt, input int dur);
      int rf, last, rec, lst, n;
      int op_n, op_first, dn_n, dn_at, rc_n, wr_bad, cap_bad, bz_n;
      bit exp_wr;
      model(clr, timed, halt, dur, rf, last, rec, lst);
      n = (last < 0) ? MAXK : last + 4;
      clear_timer      = clr;
      timed_mode       = timed;
      duration         = DUR_W'(dur);
      halt_on_overflow = halt;
      play(n);
      op_n = 0; op_first = -1; dn_n = 0; dn_at = -1; rc_n = 0; wr_bad = 0; cap_bad = 0; bz_n = 0;
      for (int k = 0; k < n; k++) begin
         if (m_op[k] === 1'b1) begin
            op_n++;
            if (op_first < 0) op_first = k;
         end
         if (m_dn[k] === 1'b1) begin
            dn_n++;
            if (dn_at < 0) dn_at = k;
         end
         if (m_rc[k] === 1'b1) rc_n++;
         if (m_bz[k] === 1'b1) bz_n++;
         if (m_cap[k] !== m_op[k]) cap_bad++;
         exp_wr = (k >= rf) && (k <= last + 1) && rd[k] && !fl[k];
         if (m_wr[k] !== exp_wr) wr_bad++;
      end
      chk({tg, "_op_first"}, op_first, rf);
      chk({tg, "_op_cycles"}, op_n, last - rf + 1);
      chk({tg, "_done_count"}, dn_n, 1);
      chk({tg, "_done_at"}, dn_at, last + 2);
      chk({tg, "_reset_counter_cycles"}, rc_n, int'(clr));
      chk({tg, "_busy_cycles"}, bz_n, last + 2);
      chk({tg, "_capture_vs_counter"}, cap_bad, 0);
      chk({tg, "_fifo_wr_errors"}, wr_bad, 0);
      chk({tg, "_record_count"}, record_count, rec);
      chk({tg, "_lost_count"}, lost_count, lst);
      chk({tg, "_overflow"}, overflow, lst > 0);
   endtask

   initial begin
      reset = 1'b1;
      cmd_start = 1'b0; cmd_stop = 1'b0; clear_timer = 1'b0; timed_mode = 1'b0;
      duration = '0; halt_on_overflow = 1'b0; tagger_ready = 1'b1; fifo_full = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      @(negedge clk);
      chk("reset_ctrl_outputs", {reset_counter, counter_operate, capture_operate, fifo_wr, busy, done, overflow}, 0);
      chk("reset_record_count", record_count, 0);
      chk("reset_lost_count", lost_count, 0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      tagger_ready = 1'b0;

      // Timed run with timer clear, duration 5: clear at +1, RUN +2..+6, DRAIN +7, done +8.
      clr_stim();
      st[0] = 1'b1;
      for (int k = 0; k < 12; k++) rd[k] = 1'($urandom_range(0, 1));
      run_and_check("timed5", 1'b1, 1'b1, 1'b0, 5);
      chk("timed5_rc_at_1", m_rc[1], 1);
      chk("timed5_op_at_2", m_op[2], 1);
      chk("timed5_op_at_6", m_op[6], 1);
      chk("timed5_op_off_at_7", m_op[7], 0);
      chk("timed5_done_at_8", m_dn[8], 1);
      chk("timed5_busy_off_at_9", m_bz[9], 0);

      // Randomized timed runs; tagger_ready also toggles while idle around the window.
      for (int r = 0; r < 6; r++) begin
         bit c;
         int d;
         clr_stim();
         st[0] = 1'b1;
         c = 1'($urandom_range(0, 1));
         d = int'($urandom_range(0, 12));
         for (int k = 0; k < 20; k++) begin
            rd[k] = 1'($urandom_range(0, 1));
            fl[k] = ($urandom_range(0, 3) == 0);
         end
         run_and_check($sformatf("rand%0d_d%0d", r, d), c, 1'b1, 1'b0, d);
      end

      // Untimed run stopped on its 100th RUN cycle; a restart attempt mid-run; a record in DRAIN.
      clr_stim();
      st[0] = 1'b1;
      st[50] = 1'b1;
      sp[100] = 1'b1;
      for (int k = 1; k <= 100; k++) rd[k] = 1'($urandom_range(0, 1));
      rd[101] = 1'b1;
      run_and_check("untimed100", 1'b0, 1'b0, 1'b0, 0);
      chk("untimed100_drain_write", m_wr[101], 1);

      // FIFO full for three records without halting: run keeps going until the stop.
      clr_stim();
      st[0] = 1'b1;
      rd[5] = 1'b1; fl[5] = 1'b1;
      rd[6] = 1'b1; fl[6] = 1'b1;
      rd[7] = 1'b1;
      rd[9] = 1'b1; fl[9] = 1'b1;
      sp[15] = 1'b1;
      run_and_check("full3", 1'b0, 1'b0, 1'b0, 0);
      chk("full3_count_cleared_on_start", m_rcnt[1], 0);
      chk("full3_busy_after_losses", m_bz[12], 1);

      // Halt on overflow: first loss at offset 20 ends RUN there.
      clr_stim();
      st[0] = 1'b1;
      rd[3] = 1'b1; rd[10] = 1'b1;
      rd[20] = 1'b1; fl[20] = 1'b1;
      sp[60] = 1'b1;
      run_and_check("halt", 1'b0, 1'b0, 1'b1, 0);
      chk("halt_overflow_cleared_on_start", m_ov[1], 0);

      // Duration 0 behaves as a one-cycle window.
      clr_stim();
      st[0] = 1'b1;
      rd[1] = 1'b1; rd[2] = 1'b1; rd[3] = 1'b1;
      run_and_check("dur0", 1'b0, 1'b1, 1'b0, 0);

      // Start and stop together in IDLE: start wins, stop is ignored.
      clr_stim();
      st[0] = 1'b1; sp[0] = 1'b1;
      sp[10] = 1'b1;
      run_and_check("start_stop_idle", 1'b0, 1'b0, 1'b0, 0);

      // Reset in the middle of a run: no done, everything back to zero.
      clr_stim();
      st[0] = 1'b1;
      for (int k = 1; k < 8; k++) rd[k] = 1'b1;
      clear_timer = 1'b0; timed_mode = 1'b0; halt_on_overflow = 1'b0;
      play(8);
      chk("midrun_records_before_reset", m_rcnt[7], 6);
      reset = 1'b1;
      tagger_ready = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      tagger_ready = 1'b0;
      clr_stim();
      rd[0] = 1'b1; rd[2] = 1'b1;
      play(6);
      begin
         int bz_n, dn_n, op_n, wr_n;
         bz_n = 0; dn_n = 0; op_n = 0; wr_n = 0;
         for (int k = 0; k < 6; k++) begin
            if (m_bz[k] !== 1'b0) bz_n++;
            if (m_dn[k] !== 1'b0) dn_n++;
            if (m_op[k] !== 1'b0 || m_rc[k] !== 1'b0) op_n++;
            if (m_wr[k] !== 1'b0) wr_n++;
         end
         chk("postreset_busy_cycles", bz_n, 0);
         chk("postreset_done_cycles", dn_n, 0);
         chk("postreset_ctrl_cycles", op_n, 0);
         chk("postreset_idle_writes", wr_n, 0);
         chk("postreset_record_count", record_count, 0);
         chk("postreset_lost_count", lost_count, 0);
      end

      // A fresh run after the reset behaves normally.
      clr_stim();
      st[0] = 1'b1;
      rd[2] = 1'b1; rd[4] = 1'b1; fl[4] = 1'b1;
      run_and_check("after_reset", 1'b1, 1'b1, 1'b0, 4);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/acquisition_sequencer.md
# acquisition_sequencer

Run controller for the event tagger. Sequences one acquisition: clears the tagger timer, enables counting and capture for a commanded or timed window, then drains the tagger's final registered record. Gates tagger records into the downstream record FIFO, counts accepted and lost records, and reports overflow. Sits between the host command/status registers and the event tagger's `reset_counter` / `counter_operate` / `capture_operate` / `ready` pins.

## Interface
- `DUR_W`, 36: width of window duration; matches the tagger timer.
- `CNT_W`, 32: width of `record_count`.
- `LOST_W`, 16: width of `lost_count`.

Ports:
- `clk` in 1: single system clock.
- `reset` in 1: synchronous, active-high; returns the block to IDLE.
- `cmd_start` in 1: one-cycle pulse; begins an acquisition.
- `cmd_stop` in 1: one-cycle pulse; ends an acquisition.
- `clear_timer` in 1: sampled with `cmd_start`; 1 means pulse the tagger timer reset before running.
- `timed_mode` in 1: sampled with `cmd_start`; 1 means the window ends after `duration` cycles.
- `duration` in DUR_W: window length in cycles; sampled with `cmd_start`.
- `halt_on_overflow` in 1: 1 means a lost record ends the run.
- `tagger_ready` in 1: the tagger's record-valid output.
- `fifo_full` in 1: the record FIFO cannot accept a write this cycle.
- `reset_counter` out 1: to the tagger.
- `counter_operate` out 1: to the tagger.
- `capture_operate` out 1: to the tagger.
- `fifo_wr` out 1: write strobe for the current tagger record.
- `busy` out 1: high in any state except IDLE.
- `done` out 1: one-cycle pulse at the end of an acquisition.
- `overflow` out 1: sticky; set when a record is lost.
- `record_count` out CNT_W: records written in the current or last run.
- `lost_count` out LOST_W: records dropped in the current or last run.

## Operation
- States are IDLE, CLEAR, RUN, DRAIN and DONE. The state is registered.
- Tagger control outputs are decoded from the state register:
  - `reset_counter` = (state == CLEAR).
  - `counter_operate` = `capture_operate` = (state == RUN).
- IDLE:
  - On `cmd_start`, latch `timed_mode` and `duration` into `remaining`. A `duration` of 0 is loaded as 1.
  - Clear `record_count`, `lost_count` and `overflow`.
  - Go to CLEAR if `clear_timer` = 1, else go to RUN.
  - `cmd_stop` is ignored in IDLE. If `cmd_start` and `cmd_stop` arrive in the same cycle, start wins.
- CLEAR: lasts one cycle. Goes to RUN, or to DRAIN if `cmd_stop` is seen.
- RUN:
  - When timed, `remaining` decrements each cycle.
  - Go to DRAIN on `cmd_stop`, or when timed and `remaining` == 1, or when `halt_on_overflow` is set and a record is lost this cycle.
  - `cmd_start` is ignored while `busy`.
- DRAIN: lasts one cycle. It exists because the tagger's `ready` lags `capture_operate` by one cycle. Goes to DONE.
- DONE: lasts one cycle with `done` = 1, then goes to IDLE.
- Record gating:
  - Define `accept_window` = state is RUN or DRAIN.
  - `fifo_wr` = `tagger_ready` & !`fifo_full` & `accept_window`. This is combinational; the tagger data is already registered.
  - `tagger_ready` & `fifo_full` & `accept_window` counts as a lost record: `lost_count` increments and `overflow` is set.
  - `tagger_ready` outside `accept_window` is ignored and not counted.
- Counters are saturating: `record_count` holds at all-ones and `lost_count` holds at all-ones.
- After a clear, the first RUN cycle sees tagger timer = 0, so the tagger emits a wraparound marker record. That record is gated and counted like any other.

## Timing
- Reset value of every output and counter is 0. State after reset is IDLE.
- Start with clear at cycle t:
  - `reset_counter` is high in cycle t+1.
  - RUN begins at t+2.
- Start without clear at cycle t: RUN begins at t+1.
- Timed window: `counter_operate` and `capture_operate` are high for exactly `duration` consecutive cycles (1 cycle if `duration` = 0).
- `cmd_stop` in RUN cycle s: cycle s is the last RUN cycle, DRAIN is s+1, `done` is s+2.
- `busy` falls in the cycle after `done`.
- Reset asserted in any state:
  - Next cycle is IDLE with all outputs 0.
  - A partially completed run produces no `done`.
- Counter arithmetic: `remaining` is DUR_W bits, decrement only, never wraps. `record_count` and `lost_count` never wrap.

## Test plan
- Timed run: `clear_timer`=1, `duration`=5, start at cycle 10 -> `reset_counter` high at 11, operate outputs high at 12–16, DRAIN at 17, `done` at 18.
- Untimed run with stop: `timed_mode`=0, start, `cmd_stop` 100 cycles into RUN -> operate outputs high exactly 100 cycles. A `tagger_ready` in the DRAIN cycle is written, giving `record_count` = (records seen) + 1.
- FIFO full: hold `fifo_full`=1 for 3 `tagger_ready` pulses, `halt_on_overflow`=0 -> `fifo_wr` stays 0 for those pulses, `lost_count`=3, `overflow`=1, run continues.
- `halt_on_overflow`=1: the first lost record ends RUN -> DRAIN the next cycle, then `done`; `lost_count`=1.
- Edge cases:
  - `duration`=0 gives a 1-cycle RUN.
  - `cmd_start` while `busy` is ignored.
  - `cmd_start` and `cmd_stop` in the same cycle in IDLE starts a run.
  - `tagger_ready` in IDLE is neither written nor counted.
- Reset during RUN -> next cycle all outputs 0, state IDLE, no `done`. A following start clears the counters.
